// File: rtl/mem_dump_reader_if.sv
// Interface between mem_dump_reader and its surroundings: core store snoop,
// dmem read port and the dump stream. The dump engine uses the master modport.
interface mem_dump_reader_if #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 1024
);
    localparam int AW = $clog2(DEPTH);

    logic                  st_valid;
    logic [DATA_WIDTH-1:0] st_data;
    logic                  start;
    logic                  halt;
    logic                  rd_en;
    logic [AW-1:0]         rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;
    logic [AW-1:0]         m_index;
    logic                  m_last;
    logic                  busy;
    logic                  done;

    modport master (
        input  st_valid, st_data, start, rd_data, m_ready,
        output halt, rd_en, rd_addr, m_valid, m_data, m_index, m_last, busy, done
    );

    modport slave (
        output st_valid, st_data, start, rd_data, m_ready,
        input  halt, rd_en, rd_addr, m_valid, m_data, m_index, m_last, busy, done
    );
endinterface

// File: rtl/mem_dump_reader.sv
// Halts the core on a magic store or start pulse and streams all dmem words out in order.
// Define MEM_DUMP_PERIODIC_EN for periodic snapshot dumps that return to IDLE.
module mem_dump_reader #(
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    DEPTH        = 1024,
    parameter logic [DATA_WIDTH-1:0] MAGIC        = DATA_WIDTH'(32'hDEADBEEF),
    parameter int                    DRAIN_CYCLES = 5,
    parameter int                    PERIOD       = 100
) (
    input  logic              clk,
    input  logic              rst,
    mem_dump_reader_if.master bus
);
    localparam int AW  = $clog2(DEPTH);
    localparam int DCW = $clog2(DRAIN_CYCLES + 1);
    localparam logic [AW-1:0]  IDX_LAST   = AW'(DEPTH - 1);
    localparam logic [DCW-1:0] DRAIN_LAST = DCW'(DRAIN_CYCLES - 1);

    if (DEPTH < 2 || DRAIN_CYCLES < 1 || PERIOD < 1) begin : g_bad_param
        $error("mem_dump_reader: DEPTH>=2, DRAIN_CYCLES>=1, PERIOD>=1 required");
    end

    typedef enum logic [2:0] {IDLE, DRAIN, READ, WAIT, SEND, DONE} state_t;

    state_t                state_q, state_d;
    logic [AW-1:0]         idx_q, idx_d;
    logic [DCW-1:0]        drain_q, drain_d;
    logic [AW-1:0]         rd_addr_q;
    logic                  m_valid_q;
    logic [DATA_WIDTH-1:0] m_data_q;
    logic [AW-1:0]         m_index_q;
    logic                  m_last_q;
    logic                  ld_beat;
    logic                  trig_manual;
    logic                  trig;
    logic                  end_to_idle;

    assign trig_manual = bus.start || (bus.st_valid && bus.st_data == MAGIC);

`ifdef MEM_DUMP_PERIODIC_EN
    localparam int PW = (PERIOD > 2) ? $clog2(PERIOD) : 1;
    localparam logic [PW-1:0] IDLE_LAST = PW'(PERIOD - 1);

    logic [PW-1:0] idle_q;
    logic          snap_q;
    logic          trig_periodic;

    assign trig_periodic = (state_q == IDLE) && (idle_q == IDLE_LAST);
    assign trig          = trig_manual || trig_periodic;
    assign end_to_idle   = snap_q;

    // Counter only runs in IDLE; any trigger restarts the period from zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_q <= '0;
            snap_q <= 1'b0;
        end else begin
            if (state_q != IDLE || trig) idle_q <= '0;
            else                         idle_q <= idle_q + 1'b1;
            // A manual trigger wins over a coincident periodic one.
            if (state_q == IDLE && trig) snap_q <= !trig_manual;
        end
    end
`else
    assign trig        = trig_manual;
    assign end_to_idle = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        drain_d = drain_q;
        ld_beat = 1'b0;
        case (state_q)
            IDLE: begin
                if (trig) begin
                    state_d = DRAIN;
                    idx_d   = '0;
                    drain_d = '0;
                end
            end
            DRAIN: begin
                if (drain_q == DRAIN_LAST) state_d = READ;
                else                       drain_d = drain_q + 1'b1;
            end
            READ: state_d = WAIT;
            WAIT: begin
                state_d = SEND;
                ld_beat = 1'b1;
            end
            SEND: begin
                if (m_valid_q && bus.m_ready) begin
                    if (idx_q == IDX_LAST) begin
                        state_d = end_to_idle ? IDLE : DONE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = READ;
                    end
                end
            end
            DONE:    state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            drain_q <= drain_d;
        end
    end

    // rd_addr is loaded only on entry to READ so it holds between strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_addr_q <= '0;
        end else if (state_d == READ) begin
            rd_addr_q <= idx_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_index_q <= '0;
            m_last_q  <= 1'b0;
        end else if (ld_beat) begin
            m_valid_q <= 1'b1;
            m_data_q  <= bus.rd_data;
            m_index_q <= idx_q;
            m_last_q  <= (idx_q == IDX_LAST);
        end else if (state_q == SEND && bus.m_ready) begin
            m_valid_q <= 1'b0;
        end
    end

    assign bus.halt    = (state_q != IDLE);
    assign bus.busy    = (state_q != IDLE) && (state_q != DONE);
    assign bus.done    = (state_q == DONE);
    assign bus.rd_en   = (state_q == READ);
    assign bus.rd_addr = rd_addr_q;
    assign bus.m_valid = m_valid_q;
    assign bus.m_data  = m_data_q;
    assign bus.m_index = m_index_q;
    assign bus.m_last  = m_last_q;
endmodule

// File: tb/tb_mem_dump_reader.sv
// Randomized bench for mem_dump_reader with a cycle-level behavioural model
// (phases, due cycles, expected word sequence) checked on every falling edge.
module tb_mem_dump_reader;
    localparam int DW     = 32;
    localparam int DEPTH  = 4;
    localparam int AW     = 2;
    localparam int DRAIN  = 5;
    localparam int PERIOD = 10;
    localparam logic [DW-1:0] MAGIC = 32'hDEADBEEF;

    logic clk = 1'b0;
    logic rst = 1'b1;

    mem_dump_reader_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus();

    mem_dump_reader #(
        .DATA_WIDTH(DW), .DEPTH(DEPTH), .MAGIC(MAGIC),
        .DRAIN_CYCLES(DRAIN), .PERIOD(PERIOD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.master)
    );

    always #5 clk = ~clk;

    // dmem model: one-cycle read latency
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef enum {P_IDLE, P_DUMP, P_DONE} phase_t;
    phase_t        ph = P_IDLE;
    int            cyc = 0, trig_cyc = 0, rd_due = 0, vld_due = 0, exp_idx = 0;
    int            beats = 0, first_vld = -1, idle_n = 0, n_trig = 0;
    bit            snap = 0, stall_prev = 0, manual, per, exp_rd, exp_vld, hs;
    logic [DW-1:0] prev_data;
    logic [AW-1:0] prev_idx;
    logic [DW-1:0] got_q[$];

    always @(negedge clk) begin
        if (rst) begin
            ph         = P_IDLE;
            idle_n     = 0;
            stall_prev = 0;
        end else begin
            cyc++;
            manual  = bus.start || (bus.st_valid && bus.st_data == MAGIC);
            exp_rd  = (ph == P_DUMP) && (cyc == rd_due);
            exp_vld = (ph == P_DUMP) && (cyc >= vld_due);
            check("halt", bus.halt, ph != P_IDLE);
            check("busy", bus.busy, ph == P_DUMP);
            check("done", bus.done, ph == P_DONE);
            check("rd_en", bus.rd_en, exp_rd);
            check("m_valid", bus.m_valid, exp_vld);
            if (exp_rd) check("rd_addr", bus.rd_addr, exp_idx);
            if (bus.m_valid && exp_vld) begin
                if (stall_prev) begin
                    check("stall_data", bus.m_data, prev_data);
                    check("stall_index", bus.m_index, prev_idx);
                end else if (beats == 0) begin
                    first_vld = cyc;
                end
                check("m_index", bus.m_index, exp_idx);
                check("m_data", bus.m_data, mem[exp_idx]);
                check("m_last", bus.m_last, exp_idx == DEPTH - 1);
            end
            hs         = bus.m_valid && bus.m_ready && exp_vld;
            stall_prev = bus.m_valid && !bus.m_ready;
            prev_data  = bus.m_data;
            prev_idx   = bus.m_index;
            if (hs) begin
                got_q.push_back(bus.m_data);
                beats++;
                if (exp_idx == DEPTH - 1) begin
                    ph     = snap ? P_IDLE : P_DONE;
                    idle_n = 0;
                end else begin
                    exp_idx++;
                    rd_due  = cyc + 1;
                    vld_due = cyc + 3;
                end
            end else if (ph == P_IDLE) begin
                per = 0;
`ifdef MEM_DUMP_PERIODIC_EN
                per = (idle_n == PERIOD - 1);
`endif
                if (manual || per) begin
                    ph        = P_DUMP;
                    trig_cyc  = cyc;
                    rd_due    = cyc + DRAIN + 1;
                    vld_due   = cyc + DRAIN + 3;
                    exp_idx   = 0;
                    beats     = 0;
                    first_vld = -1;
                    snap      = !manual;
                    idle_n    = 0;
                    n_trig++;
                    got_q.delete();
                end else begin
                    idle_n++;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    int rdy_mode = 0;  // 0: always ready, 1: toggle, 2: random
    bit noise    = 0;  // random start pulses while the dump is running

    task automatic tick();
        @(posedge clk);
        #1;
        bus.st_valid = 1'b0;
        bus.start    = noise && (ph != P_IDLE) && ($urandom_range(0, 2) == 0);
        case (rdy_mode)
            0:       bus.m_ready = 1'b1;
            1:       bus.m_ready = ~bus.m_ready;
            default: bus.m_ready = 1'($urandom_range(0, 1));
        endcase
    endtask

    task automatic chk_zero(input string tag);
        check({tag, "_halt"},    bus.halt,    0);
        check({tag, "_rd_en"},   bus.rd_en,   0);
        check({tag, "_rd_addr"}, bus.rd_addr, 0);
        check({tag, "_m_valid"}, bus.m_valid, 0);
        check({tag, "_m_data"},  bus.m_data,  0);
        check({tag, "_m_index"}, bus.m_index, 0);
        check({tag, "_m_last"},  bus.m_last,  0);
        check({tag, "_busy"},    bus.busy,    0);
        check({tag, "_done"},    bus.done,    0);
    endtask

    task automatic do_reset();
        noise = 0;
        rst   = 1'b1;
        repeat (2) tick();
        chk_zero("reset");
        rst = 1'b0;
    endtask

    task automatic fill_random();
        for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (ph != P_DONE && n < budget) begin
            tick();
            n++;
        end
        check("wait_done_timeout", ph == P_DONE, 1);
    endtask

    initial begin
        bus.st_valid = 1'b0;
        bus.st_data  = '0;
        bus.start    = 1'b0;
        bus.m_ready  = 1'b1;
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;

        // Magic store with fixed contents; pins latency and data literally.
        do_reset();
        mem[0] = 11; mem[1] = 22; mem[2] = 33; mem[3] = 44;
        rdy_mode = 0;
        bus.st_valid = 1'b1;
        bus.st_data  = MAGIC;
        tick();
        wait_done(100);
        check("first_valid_latency", first_vld - trig_cyc, 8);
        check("beat_count", beats, 4);
        if (got_q.size() == 4) begin
            check("beat0", got_q[0], 11);
            check("beat1", got_q[1], 22);
            check("beat2", got_q[2], 33);
            check("beat3", got_q[3], 44);
        end else begin
            check("beat_queue_size", got_q.size(), 4);
        end
        repeat (4) tick();
        check("done_held", bus.done, 1);

        // Near-miss store must not trigger; a later start does.
        do_reset();
        fill_random();
        bus.st_valid = 1'b1;
        bus.st_data  = MAGIC - 1;
        tick();
        repeat (5) tick();
        check("near_miss_no_halt", bus.halt, 0);
        bus.start = 1'b1;
        tick();
        wait_done(100);
        check("near_miss_then_start_beats", beats, 4);

        // Backpressure toggling every cycle.
        do_reset();
        fill_random();
        rdy_mode = 1;
        bus.start = 1'b1;
        tick();
        wait_done(200);
        check("backpressure_beats", beats, 4);

        // Extra triggers during DRAIN and SEND are ignored.
        do_reset();
        fill_random();
        rdy_mode = 2;
        bus.start = 1'b1;
        noise = 1;
        tick();
        wait_done(200);
        check("extra_trigger_beats", beats, 4);
        noise = 0;

        // Reset abort after the second beat, then restart from index 0.
        do_reset();
        fill_random();
        rdy_mode = 2;
        bus.start = 1'b1;
        tick();
        for (int n = 0; n < 200 && beats < 2; n++) tick();
        check("abort_reached_beat2", beats, 2);
        #2;
        rst = 1'b1;
        #1;
        chk_zero("abort");
        tick();
        tick();
        rst = 1'b0;
        tick();
        bus.start = 1'b1;
        tick();
        wait_done(200);
        check("restart_beats", beats, 4);
        if (got_q.size() > 0) check("restart_first_word", got_q[0], mem[0]);

        // Random dumps: random contents, backpressure, trigger source and noise.
        for (int it = 0; it < 6; it++) begin
            do_reset();
            fill_random();
            rdy_mode = $urandom_range(0, 2);
            repeat ($urandom_range(0, 3)) begin
                bus.st_valid = 1'b1;
                bus.st_data  = $urandom;
                if (bus.st_data == MAGIC) bus.st_data = 0;
                tick();
            end
            if ($urandom_range(0, 1) == 1) bus.start = 1'b1;
            else begin
                bus.st_valid = 1'b1;
                bus.st_data  = MAGIC;
            end
            noise = $urandom_range(0, 1) == 1;
            tick();
            wait_done(300);
            check("random_beats", beats, 4);
            noise = 0;
        end

`ifdef MEM_DUMP_PERIODIC_EN
        // Periodic snapshots return to IDLE; a magic store then ends in DONE.
        do_reset();
        fill_random();
        rdy_mode = 2;
        n_trig = 0;
        for (int n = 0; n < 400 && !(n_trig >= 3 && ph == P_IDLE); n++) tick();
        check("snapshots_seen", n_trig >= 3, 1);
        check("snapshot_done_low", bus.done, 0);
        bus.st_valid = 1'b1;
        bus.st_data  = MAGIC;
        tick();
        wait_done(300);
        repeat (15) tick();
        check("periodic_magic_done_held", bus.done, 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_dump_reader.md
# mem_dump_reader

Hardware read-out engine for the single-cycle core's data memory. It watches the core's store path for the end-of-test magic word, halts the core, and reads every dmem word out over a valid/ready stream in ascending address order. This gives the bench and FPGA bring-up a synthesizable result-dump path in place of simulator-only memory dumps. It sits beside the core, sharing the dmem read port through a mux controlled by `halt`.

## Interface
- `DATA_WIDTH`, 32, dmem word width
- `DEPTH`, 1024, dmem depth in words, ≥2; `AW = $clog2(DEPTH)`
- `MAGIC`, 32'hDEADBEEF, store data that triggers a dump
- `DRAIN_CYCLES`, 5, cycles held halted before the first read, ≥1
- `PERIOD`, 100, idle cycles between snapshots; used only with `MEM_DUMP_PERIODIC_EN`

Ports:
- `clk` in 1 — the single clock
- `rst` in 1 — reset, asynchronous, active-high
- `st_valid` in 1 — core executes a store this cycle
- `st_data` in DATA_WIDTH — store data (rs2 value)
- `start` in 1 — manual dump trigger pulse
- `halt` out 1 — stall core and hand the dmem read port to this block
- `rd_en` out 1 — dmem read strobe
- `rd_addr` out AW — dmem word address
- `rd_data` in DATA_WIDTH — dmem read data, valid the cycle after `rd_en`
- `m_valid` out 1 — stream word valid
- `m_ready` in 1 — stream sink ready
- `m_data` out DATA_WIDTH — dumped word
- `m_index` out AW — word index of `m_data`
- `m_last` out 1 — `m_index == DEPTH-1`
- `busy` out 1 — state ≠ IDLE/DONE
- `done` out 1 — final dump complete

## Operation
- FSM states: IDLE, DRAIN, READ, WAIT, SEND, DONE.
- IDLE: a trigger is `start`, or `st_valid && st_data == MAGIC`. On a trigger → DRAIN, with `idx` = 0 and drain count = 0. Both sources in the same cycle count as one trigger.
- DRAIN: `halt` = 1. Counts DRAIN_CYCLES cycles, then → READ. Triggers are ignored in every non-IDLE state.
- READ: `rd_en` = 1 and `rd_addr` = `idx` for exactly one cycle, then → WAIT.
- WAIT: `rd_data` is captured into `m_data` at the end of the cycle. `m_index` ← `idx`, `m_valid` ← 1, → SEND.
- SEND: `m_data`, `m_index` and `m_last` are held stable while `m_valid && !m_ready`. On handshake, `m_valid` ← 0.
  - If `idx == DEPTH-1`, → DONE.
  - Otherwise `idx` increments and → READ.
- DONE: `halt` = 1 and `done` = 1 until reset. This state is terminal.
- `rd_addr` holds its last value when `rd_en` = 0. `idx` never wraps; the dump ends at `DEPTH-1`.

## Timing
- Reset value of every output is 0: `halt`, `rd_en`, `rd_addr`, `m_valid`, `m_data`, `m_index`, `m_last`, `busy`, `done`. The FSM resets to IDLE and all counters to 0.
- `halt` and `busy` rise in the cycle after the trigger edge.
- First `rd_en` comes DRAIN_CYCLES+1 cycles after the trigger edge.
- First `m_valid` comes DRAIN_CYCLES+3 cycles after the trigger edge.
- Per-word cost is 3 cycles minimum (READ, WAIT, SEND with `m_ready` = 1). Each extra cycle with `m_ready` low adds one cycle.
- `done` rises the cycle after the `m_last` handshake.
- `rst` asserted mid-dump aborts immediately: all outputs go to 0 asynchronously and no partial state is kept.

## Configuration
- `MEM_DUMP_PERIODIC_EN` defined:
  - An idle counter increments every IDLE cycle. On reaching PERIOD−1 it auto-triggers a snapshot dump and clears to 0.
  - A snapshot dump runs exactly like a normal dump, except that after the last handshake it returns to IDLE with `halt`=0 and `done`=0.
  - A magic store or `start` arriving in the same cycle as a periodic trigger takes precedence: the dump ends in DONE.
  - The counter is held at 0 outside IDLE.
- Not defined: no idle counter and `PERIOD` is unused. Only magic/`start` triggers exist, and every dump ends in DONE.

## Test plan
- With DEPTH=4 and dmem = {11,22,33,44}, assert `st_valid` with `st_data`=32'hDEADBEEF, holding `m_ready`=1. Required response:
  - 4 beats, `m_data` 11,22,33,44 with `m_index` 0..3;
  - `m_last` asserted only on index 3;
  - first `m_valid` 8 cycles after the trigger edge;
  - `done` high the cycle after the last beat.
- `st_valid` with `st_data`=32'hDEADBEEE, then `start` → no dump on the first; the second dumps normally.
- Backpressure: toggle `m_ready` 0/1 every cycle during a dump → `m_data` and `m_index` stable while stalled, no word lost or duplicated, all 4 beats delivered.
- Extra trigger: assert `start` during DRAIN and again during SEND → ignored; exactly 4 beats are emitted.
- Reset abort: assert `rst` after the 2nd beat → all outputs 0 at once. A fresh `start` after release restarts from index 0.
- With `MEM_DUMP_PERIODIC_EN` and PERIOD=10:
  - no stores → a snapshot dump every 10 idle cycles, `halt` dropping after each and `done` staying 0;
  - a magic store → DONE held.
